aes_hex_pager: RTL

//  Downstream display stage for the AES datapath. Captures a 128-bit result word (decrypted

---
 rtl/aes_disp_pkg.sv | 39 +++
 rtl/aes_hex_pager_key_debounce.sv | 42 ++++
 rtl/aes_hex_pager.sv | 100 ++++++++++
 3 files changed

// File: rtl/aes_disp_pkg.sv
// Shared display definitions for the AES result pager: segment codes,
// page geometry and the pager state type.
package aes_disp_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam int NUM_PAGES = 6;
  localparam int DIGITS    = 6;

  typedef enum logic {
    IDLE = 1'b0,
    SHOW = 1'b1
  } disp_state_e;

  // Active-low {g,f,e,d,c,b,a} pattern for one hex nibble.
  function automatic logic [6:0] seg_lut(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0: seg = 7'h40;
      4'h1: seg = 7'h79;
      4'h2: seg = 7'h24;
      4'h3: seg = 7'h30;
      4'h4: seg = 7'h19;
      4'h5: seg = 7'h12;
      4'h6: seg = 7'h02;
      4'h7: seg = 7'h78;
      4'h8: seg = 7'h00;
      4'h9: seg = 7'h10;
      4'hA: seg = 7'h08;
      4'hB: seg = 7'h03;
      4'hC: seg = 7'h46;
      4'hD: seg = 7'h21;
      4'hE: seg = 7'h06;
      4'hF: seg = 7'h0E;
      default: seg = SEG_BLANK;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/aes_hex_pager_key_debounce.sv
// Debouncer for one active-low push-button: 2-flop synchronizer, stability
// counter and a single-cycle pulse on each accepted press.
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int CNT_W           = 20
) (
  input  logic clk,
  input  logic rst,
  input  logic key_n_i,
  output logic press_o
);

  logic [1:0]       sync_q;
  logic             level_q;
  logic [CNT_W-1:0] cnt_q;
  logic             press_q;

  // Accepted level only moves after the synced level has disagreed for DEBOUNCE_CYCLES samples.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q  <= 2'b11;
      level_q <= 1'b1;
      cnt_q   <= '0;
      press_q <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], key_n_i};
      press_q <= 1'b0;
      if (sync_q[1] == level_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        level_q <= sync_q[1];
        cnt_q   <= '0;
        press_q <= ~sync_q[1];
      end else begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

  assign press_o = press_q;

endmodule

// File: rtl/aes_hex_pager.sv
// Captures a 128-bit AES result and pages its 32 nibbles across six
// active-low 7-segment digits, stepped by two debounced buttons.
module aes_hex_pager
  import aes_disp_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int CNT_W           = 20
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [127:0] data_in,
  input  logic         data_valid,
  input  logic [1:0]   KEY,
  output logic [6:0]   HEX0,
  output logic [6:0]   HEX1,
  output logic [6:0]   HEX2,
  output logic [6:0]   HEX3,
  output logic [6:0]   HEX4,
  output logic [6:0]   HEX5,
  output logic [2:0]   page,
  output logic         loaded
);

  localparam logic [2:0] LAST_PAGE = 3'(NUM_PAGES - 1);

  disp_state_e  state_q;
  logic [127:0] data_q;
  logic [2:0]   page_q;
  logic         loaded_q;
  logic [6:0]   hex_q [DIGITS];
  logic [6:0]   hex_d [DIGITS];
  logic [5:0]   nib_idx [DIGITS];
  logic         next_s;
  logic         prev_s;

  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_key_next (
    .clk(clk), .rst(rst), .key_n_i(KEY[0]), .press_o(next_s)
  );

  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_key_prev (
    .clk(clk), .rst(rst), .key_n_i(KEY[1]), .press_o(prev_s)
  );

  // Digit k of the current page shows nibble 6*page+k; indices past 31 stay blank.
  always_comb begin
    for (int k = 0; k < DIGITS; k++) begin
      nib_idx[k] = 6'(page_q) * 6'd6 + 6'(k);
      if (state_q == SHOW && nib_idx[k] < 6'd32) begin
        hex_d[k] = seg_lut(data_q[{nib_idx[k][4:0], 2'b00} +: 4]);
      end else begin
        hex_d[k] = SEG_BLANK;
      end
    end
  end

  // Capture always beats a button pulse; opposing pulses cancel.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      data_q   <= '0;
      page_q   <= 3'd0;
      loaded_q <= 1'b0;
      for (int k = 0; k < DIGITS; k++) hex_q[k] <= SEG_BLANK;
    end else begin
      for (int k = 0; k < DIGITS; k++) hex_q[k] <= hex_d[k];
      case (state_q)
        IDLE: begin
          if (data_valid) begin
            state_q  <= SHOW;
            data_q   <= data_in;
            page_q   <= 3'd0;
            loaded_q <= 1'b1;
          end
        end
        SHOW: begin
          if (data_valid) begin
            data_q   <= data_in;
            page_q   <= 3'd0;
            loaded_q <= 1'b1;
          end else if (next_s && !prev_s) begin
            page_q <= (page_q == LAST_PAGE) ? 3'd0 : page_q + 3'd1;
          end else if (prev_s && !next_s) begin
            page_q <= (page_q == 3'd0) ? LAST_PAGE : page_q - 3'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign HEX0   = hex_q[0];
  assign HEX1   = hex_q[1];
  assign HEX2   = hex_q[2];
  assign HEX3   = hex_q[3];
  assign HEX4   = hex_q[4];
  assign HEX5   = hex_q[5];
  assign page   = page_q;
  assign loaded = loaded_q;

endmodule
